// File: rtl/sd_sched_pkg.sv
// rtl/sd_sched_pkg.sv - shared types and defaults for the SD read scheduler
package sd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic REQ_TILE = 1'b0;
  localparam logic REQ_AUD  = 1'b1;

  localparam int unsigned DEF_BLOCK_BYTES    = 512;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;
  localparam int unsigned DEF_AUD_STREAK_MAX = 4;

endpackage

// File: rtl/sd_read_scheduler_if.sv
// rtl/sd_read_scheduler_if.sv - SD byte stream and requester bundle; master = scheduler side
interface sd_read_scheduler_if;
  logic        SdReady;
  logic        SdByteValid;
  logic [7:0]  SdData;
  logic        SdStart;
  logic [23:0] SdAddress;
  logic        TileReq;
  logic [23:0] TileAddr;
  logic        AudReq;
  logic [23:0] AudAddr;
  logic        TileGrant;
  logic        AudGrant;
  logic [7:0]  ByteOut;
  logic        TileByteValid;
  logic        AudByteValid;
  logic        BlockDone;
  logic        ErrTimeout;
  logic [15:0] TileBlockCount;
  logic [15:0] AudBlockCount;

  modport master (
    input  SdReady, SdByteValid, SdData, TileReq, TileAddr, AudReq, AudAddr,
    output SdStart, SdAddress, TileGrant, AudGrant, ByteOut, TileByteValid,
           AudByteValid, BlockDone, ErrTimeout, TileBlockCount, AudBlockCount
  );

  modport slave (
    output SdReady, SdByteValid, SdData, TileReq, TileAddr, AudReq, AudAddr,
    input  SdStart, SdAddress, TileGrant, AudGrant, ByteOut, TileByteValid,
           AudByteValid, BlockDone, ErrTimeout, TileBlockCount, AudBlockCount
  );
endinterface

// File: rtl/sd_sched_arbiter.sv
// rtl/sd_sched_arbiter.sv - audio-priority winner select with tile anti-starvation streak
module sd_sched_arbiter
  import sd_sched_pkg::*;
#(
  parameter int unsigned AUD_STREAK_MAX = DEF_AUD_STREAK_MAX
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic eval_i,
  input  logic tile_req_i,
  input  logic aud_req_i,
  output logic grant_o,
  output logic winner_o
);

  localparam int unsigned SW = $clog2(AUD_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(AUD_STREAK_MAX);

  logic [SW-1:0] streak_q, streak_d;
  logic          tile_wins;

  always_comb begin
    tile_wins = tile_req_i && (!aud_req_i || (streak_q == STREAK_MAX));
    grant_o   = eval_i && (tile_req_i || aud_req_i);
    winner_o  = tile_wins ? REQ_TILE : REQ_AUD;
    streak_d  = streak_q;
    // Only audio wins that actually starved a waiting tile count toward the streak.
    if (grant_o) begin
      if (tile_wins) begin
        streak_d = '0;
      end else if (tile_req_i && (streak_q != STREAK_MAX)) begin
        streak_d = streak_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/sd_read_scheduler.sv
// rtl/sd_read_scheduler.sv - one-block-at-a-time SD read arbiter and byte router
// Optional per-requester block statistics: SD_SCHED_STATS_EN
module sd_read_scheduler
  import sd_sched_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES    = DEF_BLOCK_BYTES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned AUD_STREAK_MAX = DEF_AUD_STREAK_MAX
) (
  input logic                 MasterCLK,
  input logic                 Reset,
  sd_read_scheduler_if.master bus
);

  localparam logic [9:0]  LAST_BYTE = 10'(BLOCK_BYTES - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [23:0] addr_q, addr_d;
  logic [7:0]  byte_q, byte_d;
  logic        tile_grant_q, tile_grant_d, aud_grant_q, aud_grant_d;
  logic        sd_start_q, sd_start_d, done_q, done_d, err_q, err_d;
  logic        tile_bv_q, tile_bv_d, aud_bv_q, aud_bv_d;
  logic        arb_grant, arb_winner, last_byte;

  sd_sched_arbiter #(.AUD_STREAK_MAX(AUD_STREAK_MAX)) u_arb (
    .clk_i      (MasterCLK),
    .rst_ni     (Reset),
    .eval_i     ((state_q == IDLE) && bus.SdReady),
    .tile_req_i (bus.TileReq),
    .aud_req_i  (bus.AudReq),
    .grant_o    (arb_grant),
    .winner_o   (arb_winner)
  );

  assign last_byte = (state_q == STREAM) && bus.SdByteValid && (byte_cnt_q == LAST_BYTE);

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    to_cnt_d     = to_cnt_q;
    addr_d       = addr_q;
    byte_d       = byte_q;
    tile_grant_d = tile_grant_q;
    aud_grant_d  = aud_grant_q;
    err_d        = err_q;
    sd_start_d   = 1'b0;
    done_d       = 1'b0;
    tile_bv_d    = 1'b0;
    aud_bv_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arb_grant) begin
          state_d      = ISSUE;
          addr_d       = (arb_winner == REQ_AUD) ? bus.AudAddr : bus.TileAddr;
          tile_grant_d = (arb_winner == REQ_TILE);
          aud_grant_d  = (arb_winner == REQ_AUD);
          sd_start_d   = 1'b1;
          err_d        = 1'b0;
          byte_cnt_d   = '0;
          to_cnt_d     = '0;
        end
      end
      ISSUE: state_d = STREAM;
      STREAM: begin
        if (bus.SdByteValid) begin
          byte_d     = bus.SdData;
          tile_bv_d  = tile_grant_q;
          aud_bv_d   = aud_grant_q;
          to_cnt_d   = '0;
          byte_cnt_d = byte_cnt_q + 10'd1;
          if (last_byte) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d      = IDLE;
        tile_grant_d = 1'b0;
        aud_grant_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MasterCLK) begin
    if (!Reset) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      to_cnt_q     <= '0;
      addr_q       <= '0;
      byte_q       <= '0;
      tile_grant_q <= 1'b0;
      aud_grant_q  <= 1'b0;
      sd_start_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      tile_bv_q    <= 1'b0;
      aud_bv_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      to_cnt_q     <= to_cnt_d;
      addr_q       <= addr_d;
      byte_q       <= byte_d;
      tile_grant_q <= tile_grant_d;
      aud_grant_q  <= aud_grant_d;
      sd_start_q   <= sd_start_d;
      done_q       <= done_d;
      err_q        <= err_d;
      tile_bv_q    <= tile_bv_d;
      aud_bv_q     <= aud_bv_d;
    end
  end

`ifdef SD_SCHED_STATS_EN
  logic [15:0] tile_blk_q, aud_blk_q;

  // Aborted blocks never reach last_byte, so only successful reads are counted.
  always_ff @(posedge MasterCLK) begin
    if (!Reset) begin
      tile_blk_q <= '0;
      aud_blk_q  <= '0;
    end else begin
      if (last_byte && tile_grant_q) tile_blk_q <= tile_blk_q + 16'd1;
      if (last_byte && aud_grant_q)  aud_blk_q  <= aud_blk_q + 16'd1;
    end
  end

  assign bus.TileBlockCount = tile_blk_q;
  assign bus.AudBlockCount  = aud_blk_q;
`else
  assign bus.TileBlockCount = '0;
  assign bus.AudBlockCount  = '0;
`endif

  assign bus.SdStart       = sd_start_q;
  assign bus.SdAddress     = addr_q;
  assign bus.TileGrant     = tile_grant_q;
  assign bus.AudGrant      = aud_grant_q;
  assign bus.ByteOut       = byte_q;
  assign bus.TileByteValid = tile_bv_q;
  assign bus.AudByteValid  = aud_bv_q;
  assign bus.BlockDone     = done_q;
  assign bus.ErrTimeout    = err_q;

endmodule

// File: tb/tb_sd_read_scheduler.sv
// tb/tb_sd_read_scheduler.sv - scoreboard bench for sd_read_scheduler
module tb_sd_read_scheduler;

  localparam int BLK = 512;
  localparam int TO  = 16;

  typedef struct packed {
    logic        owner;
    logic [7:0]  data;
    logic [31:0] at;
  } exp_byte_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   exp_tile_blocks = 0;
  int   exp_aud_blocks = 0;
  exp_byte_t sb[$];
  exp_byte_t e;

  sd_read_scheduler_if bus ();

  sd_read_scheduler #(
    .BLOCK_BYTES    (BLK),
    .TIMEOUT_CYCLES (TO),
    .AUD_STREAK_MAX (4)
  ) dut (
    .MasterCLK (clk),
    .Reset     (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] exp_tc();
`ifdef SD_SCHED_STATS_EN
    return 16'(exp_tile_blocks);
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_ac();
`ifdef SD_SCHED_STATS_EN
    return 16'(exp_aud_blocks);
`else
    return 16'd0;
`endif
  endfunction

  // Output monitor: one-hot grants and scoreboarded byte forwarding with exact latency.
  always @(negedge clk) begin
    vectors++;
    if (bus.TileGrant === 1'b1 && bus.AudGrant === 1'b1) begin
      miscompares++;
      $display("FAIL grant_onehot: tile=%0b aud=%0b, required not both", bus.TileGrant, bus.AudGrant);
    end
    if (bus.TileByteValid === 1'b1 || bus.AudByteValid === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_byte: tile_v=%0b aud_v=%0b data=%h at cyc %0d, required no byte",
                 bus.TileByteValid, bus.AudByteValid, bus.ByteOut, cyc);
      end else begin
        e = sb.pop_front();
        if ({bus.AudByteValid, bus.TileByteValid, bus.ByteOut, 32'(cyc)} !== {e.owner, ~e.owner, e.data, e.at}) begin
          miscompares++;
          $display("FAIL byte_fwd: aud_v=%0b tile_v=%0b data=%h cyc=%0d, required aud_v=%0b tile_v=%0b data=%h cyc=%0d",
                   bus.AudByteValid, bus.TileByteValid, bus.ByteOut, cyc, e.owner, ~e.owner, e.data, e.at);
        end
      end
    end
  end

  task automatic wait_start(input bit owner, input logic [23:0] addr, input int exp_lat);
    int k = 0;
    while (bus.SdStart !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (bus.SdStart !== 1'b1) begin
      miscompares++;
      $display("FAIL start_wait: SdStart=%b after %0d cycles, required 1", bus.SdStart, k);
    end else begin
      if ({bus.SdAddress, bus.AudGrant, bus.TileGrant, bus.ErrTimeout} !== {addr, owner, ~owner, 1'b0}) begin
        miscompares++;
        $display("FAIL issue: addr=%h aud=%b tile=%b err=%b, required addr=%h aud=%b tile=%b err=0",
                 bus.SdAddress, bus.AudGrant, bus.TileGrant, bus.ErrTimeout, addr, owner, ~owner);
      end
      if (exp_lat >= 0) begin
        vectors++;
        if (k != exp_lat) begin
          miscompares++;
          $display("FAIL regrant_latency: %0d cycles, required %0d", k, exp_lat);
        end
      end
    end
  endtask

  task automatic send_bytes(input bit owner, input int n, input bit fwd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        vectors++;
        if (bus.SdStart !== 1'b0) begin
          miscompares++;
          $display("FAIL start_pulse: SdStart=%b, required 0", bus.SdStart);
        end
      end
      bus.SdByteValid = 1'b1;
      bus.SdData = 8'($urandom);
      if (fwd) sb.push_back('{owner, bus.SdData, 32'(cyc + 1)});
    end
    @(posedge clk);
    #1;
    bus.SdByteValid = 1'b0;
  endtask

  task automatic finish_ok(input bit owner);
    @(negedge clk);
    if (owner) exp_aud_blocks++;
    else exp_tile_blocks++;
    vectors++;
    if ({bus.BlockDone, bus.ErrTimeout, bus.AudGrant, bus.TileGrant, bus.TileBlockCount, bus.AudBlockCount}
        !== {1'b1, 1'b0, owner, ~owner, exp_tc(), exp_ac()}) begin
      miscompares++;
      $display("FAIL block_done: done=%b err=%b aud=%b tile=%b tcnt=%0d acnt=%0d, required done=1 err=0 aud=%b tile=%b tcnt=%0d acnt=%0d",
               bus.BlockDone, bus.ErrTimeout, bus.AudGrant, bus.TileGrant, bus.TileBlockCount,
               bus.AudBlockCount, owner, ~owner, exp_tc(), exp_ac());
    end
  endtask

  task automatic check_all_zero(input string name);
    vectors++;
    if ({bus.SdStart, bus.SdAddress, bus.TileGrant, bus.AudGrant, bus.ByteOut, bus.TileByteValid,
         bus.AudByteValid, bus.BlockDone, bus.ErrTimeout, bus.TileBlockCount, bus.AudBlockCount} !== '0) begin
      miscompares++;
      $display("FAIL %s: start=%b addr=%h tg=%b ag=%b byte=%h tv=%b av=%b done=%b err=%b tc=%0d ac=%0d, required all 0",
               name, bus.SdStart, bus.SdAddress, bus.TileGrant, bus.AudGrant, bus.ByteOut, bus.TileByteValid,
               bus.AudByteValid, bus.BlockDone, bus.ErrTimeout, bus.TileBlockCount, bus.AudBlockCount);
    end
  endtask

  task automatic test_reset();
    bus.SdReady = 1'b0; bus.SdByteValid = 1'b0; bus.SdData = '0;
    bus.TileReq = 1'b0; bus.TileAddr = '0; bus.AudReq = 1'b0; bus.AudAddr = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_idle_drop();
    bus.SdReady = 1'b1;
    repeat (3) send_bytes(1'b0, 1, 1'b0);
    @(negedge clk);
    vectors++;
    if ({bus.TileByteValid, bus.AudByteValid, bus.TileGrant, bus.AudGrant} !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_drop: tv=%b av=%b tg=%b ag=%b, required all 0",
               bus.TileByteValid, bus.AudByteValid, bus.TileGrant, bus.AudGrant);
    end
  endtask

  task automatic test_single_audio();
    bus.SdReady = 1'b0;
    bus.AudAddr = 24'h000018;
    bus.AudReq = 1'b1;
    repeat (6) begin
      @(negedge clk);
      vectors++;
      if ({bus.SdStart, bus.AudGrant} !== 2'b00) begin
        miscompares++;
        $display("FAIL not_ready: start=%b grant=%b, required 0 0", bus.SdStart, bus.AudGrant);
      end
    end
    bus.SdReady = 1'b1;
    wait_start(1'b1, 24'h000018, -1);
    bus.AudReq = 1'b0;
    send_bytes(1'b1, BLK, 1'b1);
    finish_ok(1'b1);
  endtask

  task automatic test_arbitration();
    bit exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    bus.TileAddr = 24'h100000;
    bus.AudAddr = 24'h200000;
    @(negedge clk);
    bus.TileReq = 1'b1;
    bus.AudReq = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_start(exp_order[i], exp_order[i] ? 24'h200000 : 24'h100000, (i == 0) ? -1 : 2);
      send_bytes(exp_order[i], BLK, 1'b1);
      finish_ok(exp_order[i]);
    end
    bus.TileReq = 1'b0;
    bus.AudReq = 1'b0;
  endtask

  task automatic test_timeout();
    int k;
    @(negedge clk);
    bus.TileAddr = 24'h000ABC;
    bus.TileReq = 1'b1;
    wait_start(1'b0, 24'h000ABC, -1);
    bus.TileReq = 1'b0;
    send_bytes(1'b0, 100, 1'b1);
    @(negedge clk);
    k = 0;
    while (bus.BlockDone !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if ({bus.BlockDone, bus.ErrTimeout, bus.TileBlockCount, 32'(k)} !== {1'b1, 1'b1, exp_tc(), 32'(TO)}) begin
      miscompares++;
      $display("FAIL timeout_abort: done=%b err=%b tcnt=%0d after %0d cycles, required done=1 err=1 tcnt=%0d after %0d",
               bus.BlockDone, bus.ErrTimeout, bus.TileBlockCount, k, exp_tc(), TO);
    end
    @(negedge clk);
    vectors++;
    if ({bus.BlockDone, bus.ErrTimeout, bus.TileGrant} !== 3'b010) begin
      miscompares++;
      $display("FAIL err_sticky: done=%b err=%b grant=%b, required done=0 err=1 grant=0",
               bus.BlockDone, bus.ErrTimeout, bus.TileGrant);
    end
    bus.AudAddr = 24'h000444;
    bus.AudReq = 1'b1;
    wait_start(1'b1, 24'h000444, -1);
    bus.AudReq = 1'b0;
    send_bytes(1'b1, BLK, 1'b1);
    finish_ok(1'b1);
  endtask

  task automatic test_reset_midblock();
    @(negedge clk);
    bus.AudAddr = 24'h000300;
    bus.AudReq = 1'b1;
    wait_start(1'b1, 24'h000300, -1);
    bus.AudReq = 1'b0;
    send_bytes(1'b1, 300, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_tile_blocks = 0;
    exp_aud_blocks = 0;
    check_all_zero("reset_midblock");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_tile_drop();
    @(negedge clk);
    bus.TileAddr = 24'h0007F0;
    bus.TileReq = 1'b1;
    wait_start(1'b0, 24'h0007F0, -1);
    bus.TileReq = 1'b0;
    send_bytes(1'b0, BLK, 1'b1);
    finish_ok(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle_drop();
    test_single_audio();
    test_arbitration();
    test_timeout();
    test_reset_midblock();
    test_tile_drop();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d bytes outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_read_scheduler.md
Name: sd_read_scheduler

Overview:
Arbitrates the single SD_SPI byte stream between two requesters: the tile loader (bulk tile bitmaps) and the audio refill path (periodic track blocks for I2S). It grants one 512-byte block read at a time, drives the SD start address, and routes returned bytes to the granted requester with per-block completion and timeout reporting. It sits between sd_spi and the AudVid tile/audio buffers, replacing ad-hoc byte-count sequencing.

Parameters:
BLOCK_BYTES, 512, bytes per granted read.
TIMEOUT_CYCLES, 65535, maximum MasterCLK cycles between bytes in STREAM before abort.
AUD_STREAK_MAX, 4, consecutive audio grants allowed while tile is pending before tile wins once.

Ports:
MasterCLK  in  1  single clock.
Reset  in  1  synchronous, active-low reset.
SdReady  in  1  sd_spi initialised and idle.
SdByteValid  in  1  one-cycle strobe, SdData valid.
SdData  in  8  byte from sd_spi.
SdStart  out  1  one-cycle read request to sd_spi.
SdAddress  out  24  block start address, held from ISSUE through DONE.
TileReq  in  1  tile loader wants a block.
TileAddr  in  24  tile block address, sampled at grant.
AudReq  in  1  audio path wants a block.
AudAddr  in  24  audio block address, sampled at grant.
TileGrant  out  1  tile owns the stream (ISSUE..DONE).
AudGrant  out  1  audio owns the stream (ISSUE..DONE).
ByteOut  out  8  registered copy of SdData.
TileByteValid  out  1  ByteOut valid for tile.
AudByteValid  out  1  ByteOut valid for audio.
BlockDone  out  1  one-cycle pulse on the last byte or on abort.
ErrTimeout  out  1  sticky; set on abort, cleared at the next grant.
TileBlockCount  out  16  stats (see Optional Feature).
AudBlockCount  out  16  stats.

Behaviour:
- Reset (Reset==0 at an edge): state IDLE. All outputs 0, byte counter 0, streak 0, SdAddress 0. Reset mid-block abandons the block with no BlockDone. Requesters must re-request.
- States: IDLE -> ISSUE -> STREAM -> DONE -> IDLE.
- IDLE: when SdReady=1 and any Req=1, choose a winner:
  - AudReq has priority.
  - Exception: if TileReq=1 and streak==AUD_STREAK_MAX, tile wins.
  - Winner's address is latched into SdAddress. Next state is ISSUE.
- Streak counter: incremented on each audio grant made while TileReq=1. Cleared on a tile grant. Saturates at AUD_STREAK_MAX.
- ISSUE (exactly 1 cycle): Grant=1, SdStart=1, ErrTimeout cleared, byte counter=0, timeout counter=0. Next state is STREAM.
- STREAM:
  - Each SdByteValid: ByteOut<=SdData and the granted requester's ByteValid<=1 on the next cycle (1-cycle latency). Counter increments. Timeout counter resets.
  - Byte number BLOCK_BYTES-1 (the last) moves to DONE.
  - Timeout counter reaching TIMEOUT_CYCLES moves to DONE with ErrTimeout<=1.
- DONE (1 cycle): BlockDone=1, coincident with the last ByteValid, or alone on abort. Per-requester block count increments only on success. Grant drops on the next edge. Next state is IDLE.
- The earliest re-grant is the cycle after DONE (IDLE evaluation), which gives back-to-back blocks with 2 dead cycles.
- Req deassertion after grant is ignored; the block always completes or times out.
- Req changes during ISSUE/STREAM do not affect the current owner.
- SdByteValid in IDLE/ISSUE/DONE is dropped and not forwarded.
- Grants are one-hot. TileGrant and AudGrant are never both 1.
- Counters are 10-bit byte and 16-bit timeout. Block counts wrap at 16'hFFFF->0.

Optional Feature:
SD_SCHED_STATS_EN:
- Defined: TileBlockCount/AudBlockCount count successful blocks per requester and reset to 0.
- Undefined: both ports are constant 0 and the counters are not synthesised.
- Arbitration is identical in both cases.

Decomposition:
- Package sd_sched_pkg:
  - State enum (IDLE, ISSUE, STREAM, DONE).
  - Requester id constants (REQ_TILE=0, REQ_AUD=1).
  - Defaults for BLOCK_BYTES and TIMEOUT_CYCLES.
- One sub-module, sd_sched_arbiter: combinational winner select plus the streak register. All else stays in the top.

Test Plan:
- AudReq=1 with AudAddr=24'h000018, SdReady=1 -> SdStart pulses 1 cycle with SdAddress=24'h000018. 512 SdByteValid produce 512 AudByteValid, 1 cycle delayed, data equal. BlockDone occurs on byte 512. AudBlockCount=1 with SD_SCHED_STATS_EN defined.
- TileReq and AudReq held high continuously -> grant order A,A,A,A,T,A,A,A,A,T; no simultaneous grants.
- Stall after 100 bytes with TIMEOUT_CYCLES=16 -> DONE 16 cycles later. BlockDone=1, ErrTimeout=1, count not incremented. ErrTimeout clears at the next ISSUE.
- Reset low during STREAM byte 300 -> next edge all outputs 0 and state IDLE. No BlockDone. A new request is served from byte 0.
- TileReq dropped after grant -> tile block still completes 512 bytes.
- SdByteValid pulsed in IDLE -> no ByteValid on either requester.
